// File: rtl/sn74151_demux_deser_if.sv
// Pin bundle for the sn74151 demux/deserializer part model (pins 3..20).
// The driving side uses master, and the chip model uses slave.
interface sn74151_demux_deser_if;
  logic p3;   // E_BAR
  logic p4;   // D
  logic p5;   // MODE
  logic p6;   // S0
  logic p7;   // S1
  logic p8;   // S2
  logic p9;   // FRAME_BAR
  logic p10;  // GND
  logic p11, p12, p13, p14, p15, p16, p17, p18;  // Q0..Q7
  logic p19;  // RDY
  logic p20;  // VCC

  modport master (
    output p3, p4, p5, p6, p7, p8, p9, p10, p20,
    input  p11, p12, p13, p14, p15, p16, p17, p18, p19
  );

  modport slave (
    input  p3, p4, p5, p6, p7, p8, p9, p10, p20,
    output p11, p12, p13, p14, p15, p16, p17, p18, p19
  );
endinterface

// File: rtl/sn74151_demux_deser.sv
// Receiving end of an sn74151-driven serial link. Bits are steered to eight latches,
// either by an external address or by a framed auto-incrementing count with a staged byte.
module sn74151_demux_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic p1,  // CLK
  input logic p2,  // RST
  sn74151_demux_deser_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state;
  logic [7:0]  q;
  logic [7:0]  stage;
  logic [7:0]  word;
  logic [2:0]  cnt;
  logic [2:0]  addr;
  logic        rdy;
  logic        active;

  assign active = bus.p20 & ~bus.p10 & ~bus.p3;
  assign addr   = {bus.p8, bus.p7, bus.p6};

  function automatic logic [2:0] pos(input logic [2:0] c);
    return MSB_FIRST ? (3'd7 - c) : c;
  endfunction

  // Staged byte with the current bit merged in; becomes Q on the eighth bit.
  always_comb begin
    word = stage;
    word[pos(cnt)] = bus.p4;
  end

  always_ff @(posedge p1 or posedge p2) begin
    if (p2) begin
      q     <= 8'h00;
      stage <= 8'h00;
      cnt   <= 3'd0;
      rdy   <= 1'b0;
      state <= IDLE;
    end else begin
      rdy <= 1'b0;
      if (active) begin
        if (!bus.p5) begin
          q[addr] <= bus.p4;
          rdy     <= (addr == 3'd7);
          cnt     <= 3'd0;
          state   <= IDLE;
        end else if (!bus.p9) begin
          // Start or restart of a frame: the partial byte is simply overwritten.
          stage[pos(3'd0)] <= bus.p4;
          cnt              <= 3'd1;
          state            <= RECV;
        end else if (state == RECV) begin
          if (cnt == 3'd7) begin
            q     <= word;
            rdy   <= 1'b1;
            cnt   <= 3'd0;
            state <= IDLE;
          end else begin
            stage <= word;
            cnt   <= cnt + 3'd1;
          end
        end
      end
    end
  end

  assign bus.p11 = q[0];
  assign bus.p12 = q[1];
  assign bus.p13 = q[2];
  assign bus.p14 = q[3];
  assign bus.p15 = q[4];
  assign bus.p16 = q[5];
  assign bus.p17 = q[6];
  assign bus.p18 = q[7];
  assign bus.p19 = rdy;

endmodule

// File: tb/tb_sn74151_demux_deser.sv
// Bench for sn74151_demux_deser: one LSB-first and one MSB-first instance share inputs
// and are compared every cycle against a frame-level model built on a bit queue.
module tb_sn74151_demux_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e_bar = 1'b0, d = 1'b0, mode = 1'b0, frame_bar = 1'b1;
  logic [2:0] addr = 3'd0;
  logic       gnd = 1'b0, vcc = 1'b1;

  int total = 0;
  int bad   = 0;

  sn74151_demux_deser_if bus_a ();
  sn74151_demux_deser_if bus_b ();

  assign bus_a.p3 = e_bar;  assign bus_b.p3 = e_bar;
  assign bus_a.p4 = d;      assign bus_b.p4 = d;
  assign bus_a.p5 = mode;   assign bus_b.p5 = mode;
  assign bus_a.p6 = addr[0]; assign bus_b.p6 = addr[0];
  assign bus_a.p7 = addr[1]; assign bus_b.p7 = addr[1];
  assign bus_a.p8 = addr[2]; assign bus_b.p8 = addr[2];
  assign bus_a.p9 = frame_bar; assign bus_b.p9 = frame_bar;
  assign bus_a.p10 = gnd;   assign bus_b.p10 = gnd;
  assign bus_a.p20 = vcc;   assign bus_b.p20 = vcc;

  sn74151_demux_deser #(.MSB_FIRST(1'b0)) dut_a (.p1(clk), .p2(rst), .bus(bus_a.slave));
  sn74151_demux_deser #(.MSB_FIRST(1'b1)) dut_b (.p1(clk), .p2(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  logic [7:0] q_a, q_b;
  logic       rdy_a, rdy_b;
  assign q_a = {bus_a.p18, bus_a.p17, bus_a.p16, bus_a.p15, bus_a.p14, bus_a.p13, bus_a.p12, bus_a.p11};
  assign q_b = {bus_b.p18, bus_b.p17, bus_b.p16, bus_b.p15, bus_b.p14, bus_b.p13, bus_b.p12, bus_b.p11};
  assign rdy_a = bus_a.p19;
  assign rdy_b = bus_b.p19;

  // Reference model: a frame is a queue of received bits, assembled when it holds eight.
  logic [7:0] mq_a = 8'h00, mq_b = 8'h00;
  logic       mrdy = 1'b0;
  bit         in_frame = 1'b0;
  bit         mbits[$];

  int cycnum = 0;
  int pulses = 0;
  int last_pulse = -1;
  int gap = 0;

  function automatic logic [7:0] assemble(input bit msb_first);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (mbits[i]) r[msb_first ? 7 - i : i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    mq_a = 8'h00; mq_b = 8'h00; mrdy = 1'b0; in_frame = 1'b0; mbits.delete();
  endtask

  task automatic model_edge();
    mrdy = 1'b0;
    if (vcc && !gnd && !e_bar) begin
      if (!mode) begin
        mq_a[addr] = d;
        mq_b[addr] = d;
        mrdy = (addr == 3'd7);
        in_frame = 1'b0;
        mbits.delete();
      end else if (!frame_bar) begin
        mbits.delete();
        mbits.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        mbits.push_back(d);
        if (mbits.size() == 8) begin
          mq_a = assemble(1'b0);
          mq_b = assemble(1'b1);
          mrdy = 1'b1;
          in_frame = 1'b0;
          mbits.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed {rdy,q}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_lsb"}, {rdy_a, q_a}, {mrdy, mq_a});
    chk({tag, "_msb"}, {rdy_b, q_b}, {mrdy, mq_b});
  endtask

  task automatic cyc(input logic eb, input logic dd, input logic md, input logic [2:0] ad,
                     input logic fb);
    e_bar = eb; d = dd; mode = md; addr = ad; frame_bar = fb;
    @(posedge clk);
    model_edge();
    #1;
    cycnum++;
    if (rdy_a) begin
      pulses++;
      if (last_pulse >= 0) gap = cycnum - last_pulse;
      last_pulse = cycnum;
    end
    check_model("cyc");
  endtask

  task automatic send(input logic [7:0] v, input int n, input bit start);
    for (int i = 0; i < n; i++)
      cyc(1'b0, v[i], 1'b1, 3'd0, (start && i == 0) ? 1'b0 : 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("async_rst_lsb", {rdy_a, q_a}, 9'h000);
    chk("async_rst_msb", {rdy_b, q_b}, 9'h000);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lsb", {rdy_a, q_a}, 9'h000);
    chk("reset_msb", {rdy_b, q_b}, 9'h000);
    rst = 1'b0;

    // Fill Q with addressed writes, then an asynchronous reset between clocks
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 3'(i), 1'b1);
    chk("fill_ff", {rdy_a, q_a}, {1'b1, 8'hFF});
    pulse_reset();

    // Power pins: VCC low or GND high must freeze Q
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b1);
    vcc = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'(i), 1'b0, 3'(i), 1'b1);
    chk("vcc_off", {rdy_a, q_a}, {1'b0, 8'h04});
    vcc = 1'b1; gnd = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
    gnd = 1'b0;
    chk("gnd_hi", {rdy_a, q_a}, {1'b0, 8'h04});
    pulse_reset();

    // Addressed mode
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    chk("addr3", {rdy_a, q_a}, {1'b0, 8'h08});
    cyc(1'b0, 1'b1, 1'b0, 3'd7, 1'b1);
    chk("addr7", {rdy_a, q_a}, {1'b1, 8'h88});
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("addr_rdy_drop", {rdy_a, q_a}, {1'b0, 8'h88});

    // Auto mode, stream 1,0,1,0,0,1,0,1
    send(8'hA5, 7, 1'b1);
    chk("a5_hold", {rdy_a, q_a}, {1'b0, 8'h88});
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    chk("a5_lsb", {rdy_a, q_a}, {1'b1, 8'hA5});
    chk("a5_msb", {rdy_b, q_b}, {1'b1, 8'hA5});
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    chk("a5_rdy_once", {rdy_a, q_a}, {1'b0, 8'hA5});

    // Stall for three clocks after the fourth bit
    send(8'h3C, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'(i), 1'b1, 3'd0, 1'(i));
      chk("stall_rdy", {rdy_a, q_a}, {1'b0, 8'hA5});
    end
    for (int i = 4; i < 8; i++) cyc(1'b0, 1'((8'h3C >> i) & 8'h01), 1'b1, 3'd0, 1'b1);
    chk("stall_3c", {rdy_a, q_a}, {1'b1, 8'h3C});

    // Restart: a partial FF frame is abandoned for a full 12 frame
    pulses = 0;
    send(8'hFF, 5, 1'b1);
    send(8'h12, 8, 1'b1);
    chk("restart_12", {rdy_a, q_a}, {1'b1, 8'h12});
    chk("restart_pulses", 9'(pulses), 9'd1);

    // Mode switch mid-frame
    send(8'h0F, 4, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
    chk("mode_switch", {rdy_a, q_a}, {1'b0, 8'h32});
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    chk("idle_no_capture", {rdy_a, q_a}, {1'b0, 8'h32});

    // Back-to-back frames
    pulses = 0; last_pulse = -1; gap = 0;
    send(8'h55, 8, 1'b1);
    chk("b2b_55", {rdy_a, q_a}, {1'b1, 8'h55});
    send(8'hAA, 8, 1'b1);
    chk("b2b_aa", {rdy_a, q_a}, {1'b1, 8'hAA});
    chk("b2b_pulses", 9'(pulses), 9'd2);
    chk("b2b_gap", 9'(gap), 9'd8);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) pulse_reset();
      vcc = ($urandom_range(0, 31) != 0);
      gnd = ($urandom_range(0, 47) == 0);
      cyc(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 5) != 0),
          3'($urandom), 1'($urandom_range(0, 9) != 0));
    end
    vcc = 1'b1; gnd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
